// File: rtl/mem_port_arbiter_if.sv
// Request/grant/data bundle shared by the CPU port, the host port and the RAM side
// of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_lock;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: round-robin between
// CPU and host, optional host lock with a forced release after LOCK_MAX cycles,
// and a saturating count of cycles in which a requester was held off.
module mem_port_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_port_arbiter_if.slave bus,
  output logic             lock_timeout,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conflict_cnt
);
  localparam int LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCK} state_t;
  typedef enum logic {CPU, HOST} port_t;

  state_t         state, state_next;
  port_t          last_gnt, last_gnt_next;
  logic [LCW-1:0] lock_cnt, lock_cnt_next;
  logic           lock_timeout_next;
  logic           cpu_rvalid_q, host_rvalid_q;
  logic           held_off;

  // Grant selection and lock FSM next-state; grants are forced low during reset
  always_comb begin
    bus.cpu_gnt       = 1'b0;
    bus.host_gnt      = 1'b0;
    state_next        = state;
    last_gnt_next     = last_gnt;
    lock_cnt_next     = lock_cnt;
    lock_timeout_next = 1'b0;
    if (reset_n) begin
      unique case (state)
        ARB: begin
          if (bus.cpu_req && bus.host_req) begin
            bus.cpu_gnt  = (last_gnt == HOST);
            bus.host_gnt = (last_gnt == CPU);
          end else begin
            bus.cpu_gnt  = bus.cpu_req;
            bus.host_gnt = bus.host_req;
          end
          if (bus.cpu_gnt) last_gnt_next = CPU;
          if (bus.host_gnt) begin
            last_gnt_next = HOST;
            if (bus.host_lock) begin
              state_next    = LOCK;
              lock_cnt_next = LCW'(1);
            end
          end
        end
        LOCK: begin
          bus.host_gnt  = bus.host_req;
          lock_cnt_next = lock_cnt + 1'b1;
          // A voluntary release wins over a coinciding timeout
          if (!bus.host_lock) begin
            state_next    = ARB;
            last_gnt_next = HOST;
          end else if (lock_cnt == LCW'(LOCK_MAX)) begin
            state_next        = ARB;
            last_gnt_next     = HOST;
            lock_timeout_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM bus mux from whichever port holds the grant
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (bus.cpu_gnt) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (bus.host_gnt) begin
      bus.mem_addr  = bus.host_addr;
      bus.mem_we    = bus.host_we;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  // FSM, round-robin pointer, lock counter and read-valid registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ARB;
      last_gnt      <= HOST;
      lock_cnt      <= '0;
      lock_timeout  <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state         <= state_next;
      last_gnt      <= last_gnt_next;
      lock_cnt      <= lock_cnt_next;
      lock_timeout  <= lock_timeout_next;
      cpu_rvalid_q  <= bus.cpu_gnt & ~bus.cpu_we;
      host_rvalid_q <= bus.host_gnt & ~bus.host_we;
    end
  end

  assign held_off = (bus.cpu_req & ~bus.cpu_gnt) | (bus.host_req & ~bus.host_gnt);

  // Saturating contention counter; clear takes priority over increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (held_off && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.cpu_rdata   = cpu_rvalid_q  ? bus.mem_rdata : '0;
  assign bus.host_rdata  = host_rvalid_q ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 32x8 registered-read RAM, a cycle-level model of
// the arbitration rules checked on every falling edge, and directed scenarios with
// literal expectations.
module tb_mem_port_arbiter;
  localparam int AW       = 5;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 16;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             lock_timeout;
  logic [CNT_W-1:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .lock_timeout(lock_timeout),
    .cnt_clr     (cnt_clr),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 8'hA3 : 8'(i * 13 + 7);
  endfunction

  // RAM: synchronous write, registered read
  logic [DW-1:0] ram [32];
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = init_val(i);
    bus.mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the arbiter must look like, in terms of the rules
  bit            m_locked   = 1'b0;
  int            m_used     = 0;
  bit            m_cpu_first = 1'b1;
  bit            m_rv_cpu   = 1'b0;
  bit            m_rv_host  = 1'b0;
  logic [DW-1:0] m_rd_cpu   = '0;
  logic [DW-1:0] m_rd_host  = '0;
  int            m_cnt      = 0;
  bit            m_to       = 1'b0;
  logic [DW-1:0] mdl_mem [32];
  initial for (int i = 0; i < 32; i++) mdl_mem[i] = init_val(i);

  always @(negedge clk) begin : scoreboard
    bit            ec, eh, held;
    logic [AW-1:0] ea;
    bit            ew;
    logic [DW-1:0] ed;
    if (!reset_n) begin
      chk("sb_rst_cpu_gnt", bus.cpu_gnt, 0);
      chk("sb_rst_host_gnt", bus.host_gnt, 0);
      chk("sb_rst_mem_we", bus.mem_we, 0);
      chk("sb_rst_mem_addr", bus.mem_addr, 0);
      chk("sb_rst_mem_wdata", bus.mem_wdata, 0);
      chk("sb_rst_cpu_rvalid", bus.cpu_rvalid, 0);
      chk("sb_rst_host_rvalid", bus.host_rvalid, 0);
      chk("sb_rst_cnt", conflict_cnt, 0);
      chk("sb_rst_timeout", lock_timeout, 0);
      m_locked = 0; m_used = 0; m_cpu_first = 1; m_rv_cpu = 0; m_rv_host = 0;
      m_cnt = 0; m_to = 0;
    end else begin
      if (m_locked) begin
        ec = 0; eh = bus.host_req;
      end else if (bus.cpu_req && bus.host_req) begin
        ec = m_cpu_first; eh = !m_cpu_first;
      end else begin
        ec = bus.cpu_req; eh = bus.host_req;
      end
      ea = ec ? bus.cpu_addr : eh ? bus.host_addr : '0;
      ew = ec ? bus.cpu_we : eh ? bus.host_we : 1'b0;
      ed = ec ? bus.cpu_wdata : eh ? bus.host_wdata : '0;
      chk("sb_cpu_gnt", bus.cpu_gnt, ec);
      chk("sb_host_gnt", bus.host_gnt, eh);
      chk("sb_mem_addr", bus.mem_addr, ea);
      chk("sb_mem_we", bus.mem_we, ew);
      chk("sb_mem_wdata", bus.mem_wdata, ed);
      chk("sb_cpu_rvalid", bus.cpu_rvalid, m_rv_cpu);
      chk("sb_cpu_rdata", bus.cpu_rdata, m_rv_cpu ? m_rd_cpu : 0);
      chk("sb_host_rvalid", bus.host_rvalid, m_rv_host);
      chk("sb_host_rdata", bus.host_rdata, m_rv_host ? m_rd_host : 0);
      chk("sb_timeout", lock_timeout, m_to);
      chk("sb_conflict_cnt", conflict_cnt, m_cnt);
      // advance model to the next cycle
      m_rv_cpu  = ec && !bus.cpu_we;
      m_rd_cpu  = mdl_mem[bus.cpu_addr];
      m_rv_host = eh && !bus.host_we;
      m_rd_host = mdl_mem[bus.host_addr];
      if (ew) mdl_mem[ea] = ed;
      held = (bus.cpu_req && !ec) || (bus.host_req && !eh);
      if (cnt_clr) m_cnt = 0;
      else if (held && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_to = 0;
      if (m_locked) begin
        m_used++;
        if (!bus.host_lock) begin
          m_locked = 0; m_cpu_first = 1;
        end else if (m_used == LOCK_MAX) begin
          m_locked = 0; m_cpu_first = 1; m_to = 1;
        end
      end else begin
        if (ec) m_cpu_first = 0;
        if (eh) begin
          m_cpu_first = 1;
          if (bus.host_lock) begin m_locked = 1; m_used = 0; end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit c, input bit h);
    bus.cpu_req = c; bus.host_req = h;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'd1; bus.cpu_wdata = '0;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 5'd2; bus.host_wdata = '0;
    bus.host_lock = 0;
    @(negedge clk);
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_host_gnt", bus.host_gnt, 0);
    step();
    reset_n = 1;
    // Contention from reset: CPU, HOST, CPU, HOST
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_cpu_gnt", bus.cpu_gnt, (i % 2 == 0));
      step();
    end
    set_req(0, 0);
    @(negedge clk);
    chk("rr_conflict_cnt", conflict_cnt, 4);
    step();
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    // Single CPU read of addr 5
    bus.cpu_addr = 5'd5; set_req(1, 0);
    @(negedge clk);
    chk("rd_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd_mem_addr", bus.mem_addr, 5);
    chk("rd_mem_we", bus.mem_we, 0);
    step();
    set_req(0, 0);
    @(negedge clk);
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 8'hA3);
    chk("rd_conflict_cnt", conflict_cnt, 0);
    // Host write then CPU read-after-write
    step();
    bus.host_we = 1; bus.host_addr = 5'd31; bus.host_wdata = 8'h5C; set_req(0, 1);
    @(negedge clk);
    chk("wr_host_gnt", bus.host_gnt, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_wdata", bus.mem_wdata, 8'h5C);
    step();
    bus.host_we = 0; bus.cpu_addr = 5'd31; set_req(1, 0);
    @(negedge clk);
    chk("raw_cpu_gnt", bus.cpu_gnt, 1);
    chk("raw_host_rvalid", bus.host_rvalid, 0);
    step();
    set_req(0, 0);
    @(negedge clk);
    chk("raw_cpu_rdata", bus.cpu_rdata, 8'h5C);
    // Lock held until forced release
    step();
    bus.cpu_addr = 5'd3; bus.host_addr = 5'd4; bus.host_lock = 1; set_req(1, 1);
    @(negedge clk);
    chk("lk_first_host_gnt", bus.host_gnt, 1);
    for (int i = 0; i < LOCK_MAX; i++) begin
      step();
      @(negedge clk);
      chk("lk_host_gnt", bus.host_gnt, 1);
      chk("lk_cpu_gnt", bus.cpu_gnt, 0);
      chk("lk_no_timeout", lock_timeout, 0);
    end
    step();
    bus.host_lock = 0;
    @(negedge clk);
    chk("lk_timeout_pulse", lock_timeout, 1);
    chk("lk_after_cpu_gnt", bus.cpu_gnt, 1);
    step();
    @(negedge clk);
    chk("lk_timeout_end", lock_timeout, 0);
    chk("lk_after_host_gnt", bus.host_gnt, 1);
    step();
    set_req(0, 0);
    // Lock released voluntarily after 3 locked cycles
    step();
    bus.host_lock = 1; set_req(1, 1);
    @(negedge clk);
    chk("rl_c0_cpu_gnt", bus.cpu_gnt, 1);
    step();
    @(negedge clk);
    chk("rl_c1_host_gnt", bus.host_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("rl_lk_cpu_gnt", bus.cpu_gnt, 0);
    end
    step();
    bus.host_lock = 0;
    @(negedge clk);
    chk("rl_last_host_gnt", bus.host_gnt, 1);
    step();
    @(negedge clk);
    chk("rl_cpu_gnt", bus.cpu_gnt, 1);
    chk("rl_no_timeout", lock_timeout, 0);
    step();
    @(negedge clk);
    chk("rl_no_timeout2", lock_timeout, 0);
    // Saturation of the contention counter, then clear priority
    repeat (300) step();
    @(negedge clk);
    chk("sat_conflict_cnt", conflict_cnt, CNT_MAX);
    step();
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    @(negedge clk);
    chk("clr_conflict_cnt", conflict_cnt, 0);
    step();
    set_req(0, 0);
    // Reset right after a CPU read grant
    step();
    bus.cpu_addr = 5'd6; set_req(1, 0);
    @(negedge clk);
    chk("mr_cpu_gnt", bus.cpu_gnt, 1);
    step();
    reset_n = 0; set_req(1, 1);
    @(negedge clk);
    chk("mr_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("mr_cpu_gnt_forced", bus.cpu_gnt, 0);
    chk("mr_mem_addr", bus.mem_addr, 0);
    step();
    reset_n = 1;
    @(negedge clk);
    chk("mr_tie_cpu_gnt", bus.cpu_gnt, 1);
    step();
    set_req(0, 0);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32x8 synchronous program/data RAM between two requesters: the CPU core (port 0) and a host loader/debug port (port 1).
- Round-robin arbitration on contention; optional host lock for exclusive bursts (program download), bounded by a timeout.
- Sits between the requesters and the RAM; the RAM has one-cycle registered read data and a synchronous write.

Parameters:
- AW, 5, address width (32 words).
- DW, 8, data width.
- LOCK_MAX, 16, maximum consecutive cycles the host may hold the lock before a forced release.
- CNT_W, 8, width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_rvalid  out  1  read data valid (cycle after read grant).
- cpu_rdata  out  DW  read data.
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host equivalents of the CPU inputs.
- host_lock  in  1  request exclusive access after the next host grant.
- host_gnt, host_rvalid, host_rdata  out  1/1/DW  host equivalents of the CPU outputs.
- lock_timeout  out  1  one-cycle pulse on forced lock release.
- cnt_clr  in  1  synchronous clear of conflict_cnt.
- conflict_cnt  out  CNT_W  saturating count of cycles in which a request was held off.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM registered read data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Registers: state=ARB, last_gnt=HOST (CPU wins the first tie), lock_cnt=0, rvalid_*=0, conflict_cnt=0, lock_timeout=0.
  - Combinational outputs are forced: *_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Grant is combinational in cycle N.
  - mem_addr, mem_we and mem_wdata mux from the granted port in the same cycle.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - At most one *_gnt is high in any cycle.
- Read latency:
  - rvalid_x is registered as gnt_x & ~we_x, so it is high in cycle N+1.
  - rdata_x = mem_rdata while rvalid_x=1, else 0.
  - Writes produce no rvalid. A write in cycle N followed by a read of the same address in N+1 returns the new data.
- State ARB:
  - Only one req: grant it.
  - Both req: grant the port that is not last_gnt.
  - last_gnt updates on every grant.
  - host_gnt=1 with host_lock=1: next state LOCK, lock_cnt=1.
- State LOCK:
  - cpu_gnt=0 unconditionally.
  - host_gnt=host_req.
  - lock_cnt increments every cycle.
  - host_lock=0: next state ARB, last_gnt=HOST.
  - Else if lock_cnt==LOCK_MAX: next state ARB, last_gnt=HOST, lock_timeout pulses for one cycle. The host must deassert host_lock and re-request; a still-asserted host_lock re-locks only on a later host grant in ARB.
  - When host_lock=0 and lock_cnt==LOCK_MAX coincide, the release is normal: no lock_timeout.
- conflict_cnt:
  - +1 in each cycle where cpu_req&~cpu_gnt or host_req&~host_gnt (one increment per cycle, even if both are held off).
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment.
- Reset mid-operation: pending rvalid is dropped, the lock is released, and no mem_we is issued.
- Requester inputs are sampled only in the grant cycle; changes while not granted are ignored.

Test Plan:
- Single CPU read of addr 5 (RAM[5]=8'hA3), host idle -> cpu_gnt in cycle N; mem_addr=5, mem_we=0; cpu_rvalid=1, cpu_rdata=8'hA3 in N+1; conflict_cnt stays 0.
- cpu_req and host_req held for 4 cycles from reset -> grants alternate CPU, HOST, CPU, HOST; conflict_cnt=4.
- Host write 8'h5C to addr 31, then CPU read addr 31 the next cycle -> cpu_rdata=8'h5C; no host_rvalid.
- host_lock=1 with cpu_req and host_req held -> after the first host grant, host granted for LOCK_MAX cycles with cpu_gnt=0; lock_timeout pulses once; the next grant goes to the CPU.
- Same lock scenario with host_lock dropped after 3 cycles -> return to ARB, CPU granted next, no lock_timeout.
- reset_n pulsed low the cycle after a CPU read grant -> cpu_rvalid=0; all outputs at reset values; the first grant after reset goes to the CPU on a tie.
